fir_filter_mc: RTL and testbench

Multi-channel, time-multiplexed FIR filter: the parametrised successor to the single-channel fixed-tap filter. One shared multiplier-accumulator runs over per-channel sample histories. Sample input and result output use valid/ready handshakes, and coefficients are loaded at run time through a write port. The block sits between the sample source and the downstream DSP stage. It adds rounding, saturation and backpressure, none of which the earlier filter had.

---
 rtl/fir_filter_mc.sv | 193 +++++++++++++++++++
 tb/tb_fir_filter_mc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: time-multiplexed multi-channel FIR filter.
// A single multiply-accumulate unit walks one channel's delay line per
// sample, then rounds (half-up), saturates and presents the result on a
// valid/ready output. Coefficients are shared by all channels and may be
// rewritten at run time except while a MAC sequence is in flight.
module fir_filter_mc #(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int NUM_TAPS    = 8,
   parameter int NUM_CH      = 2,
   parameter int OUT_SHIFT   = 15,
   localparam int TAP_W      = $clog2(NUM_TAPS),
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          coef_we,
   input  logic [TAP_W-1:0]              coef_addr,
   input  logic signed [COEFF_WIDTH-1:0] coef_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CH_W-1:0]               in_ch,
   input  logic signed [DATA_WIDTH-1:0]  in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CH_W-1:0]               out_ch,
   output logic signed [DATA_WIDTH-1:0]  out_data
);

   localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
   // Headroom of clog2(NUM_TAPS) bits keeps the full sum of products exact.
   localparam int ACC_W  = PROD_W + TAP_W;

   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

   // Rounding constant and saturation bounds, one bit wider than the
   // accumulator so the rounding add can never wrap.
   localparam logic signed [ACC_W:0] RND_HALF = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
   localparam logic signed [ACC_W:0] SAT_MAX  =
      {{(ACC_W + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN  =
      {{(ACC_W + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [TAP_W-1:0]              tap_q, tap_d;
   logic [CH_W-1:0]               ch_q, ch_d;
   logic signed [ACC_W-1:0]       acc_q, acc_d;
   logic signed [DATA_WIDTH-1:0]  dline_q [NUM_CH][NUM_TAPS];
   logic signed [DATA_WIDTH-1:0]  dline_d [NUM_CH][NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] coef_q [NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] coef_d [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic [CH_W-1:0]               out_ch_q, out_ch_d;

   logic                          accept;
   logic                          ch_ok;
   logic                          coef_ok;
   logic signed [DATA_WIDTH-1:0]  mac_x;
   logic signed [COEFF_WIDTH-1:0] mac_c;
   logic signed [PROD_W-1:0]      mac_prod;
   logic signed [ACC_W-1:0]       acc_sum;

   // Round half-up: add one half LSB of the result, then arithmetic shift.
   function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] t;
      t = (ACC_W + 1)'(a) + RND_HALF;
      return t >>> OUT_SHIFT;
   endfunction

   // Clamp the rounded value into the signed output range.
   function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [ACC_W:0] r);
      if (r > SAT_MAX) begin
         return SAT_MAX[DATA_WIDTH-1:0];
      end else if (r < SAT_MIN) begin
         return SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         return r[DATA_WIDTH-1:0];
      end
   endfunction

   // Ready only in IDLE, and never while reset is held.
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   // Zero-extended compares stay meaningful for power-of-two sizes too.
   assign ch_ok     = ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
   assign coef_ok   = ({1'b0, coef_addr} < (TAP_W + 1)'(NUM_TAPS));

   assign out_valid = (state_q == S_OUT);
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

   // Shared MAC datapath: product of the current tap and running sum.
   always_comb begin
      mac_x    = dline_q[ch_q][tap_q];
      mac_c    = coef_q[tap_q];
      mac_prod = PROD_W'(mac_x) * PROD_W'(mac_c);
      acc_sum  = acc_q + ACC_W'(mac_prod);
   end

   // Control FSM: next state, tap counter, accumulator and output capture.
   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      ch_d       = ch_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      unique case (state_q)
         S_IDLE: begin
            // A sample for a nonexistent channel is swallowed without effect.
            if (accept && ch_ok) begin
               state_d = S_MAC;
               tap_d   = '0;
               ch_d    = in_ch;
               acc_d   = '0;
            end
         end
         S_MAC: begin
            acc_d = acc_sum;
            tap_d = tap_q + TAP_W'(1);
            if (tap_q == LAST_TAP) begin
               state_d    = S_OUT;
               tap_d      = '0;
               out_data_d = saturate(round_shift(acc_sum));
               out_ch_d   = ch_q;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Delay line update: newest sample enters tap 0 of its own channel.
   always_comb begin
      dline_d = dline_q;
      if (accept && ch_ok) begin
         for (int k = NUM_TAPS - 1; k > 0; k--) begin
            dline_d[in_ch][k] = dline_q[in_ch][k-1];
         end
         dline_d[in_ch][0] = in_data;
      end
   end

   // Coefficient port: frozen during MAC so one result sees one coefficient set.
   always_comb begin
      coef_d = coef_q;
      if (coef_we && coef_ok && (state_q != S_MAC)) begin
         coef_d[coef_addr] = coef_data;
      end
   end

   // State register; reset aborts any computation and clears all storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tap_q      <= '0;
         ch_q       <= '0;
         acc_q      <= '0;
         out_data_q <= '0;
         out_ch_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
               dline_q[c][k] <= '0;
            end
         end
         for (int k = 0; k < NUM_TAPS; k++) begin
            coef_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         tap_q      <= tap_d;
         ch_q       <= ch_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
         dline_q    <= dline_d;
         coef_q     <= coef_d;
      end
   end

endmodule

// File: tb/tb_fir_filter_mc.sv
// tb_fir_filter_mc: directed plus randomized checks of fir_filter_mc
// against a plain-arithmetic reference model of the filter.
module tb_fir_filter_mc;

   localparam int DW = 16;
   localparam int CW = 16;
   localparam int NT = 4;
   localparam int NC = 2;
   localparam int OS = 15;

   logic                 clk;
   logic                 rst;
   logic                 coef_we;
   logic [1:0]           coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [0:0]           in_ch;
   logic signed [DW-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [0:0]           out_ch;
   logic signed [DW-1:0] out_data;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int coef_m [NT];
   int hist   [NC][NT];

   fir_filter_mc #(
      .DATA_WIDTH (DW),
      .COEFF_WIDTH(CW),
      .NUM_TAPS   (NT),
      .NUM_CH     (NC),
      .OUT_SHIFT  (OS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .coef_we  (coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_ch    (in_ch),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ch   (out_ch),
      .out_data (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int k = 0; k < NT; k++) begin
         coef_m[k] = 0;
         for (int c = 0; c < NC; c++) hist[c][k] = 0;
      end
   endfunction

   function automatic void model_push(input int ch, input int d);
      if (ch < NC) begin
         for (int k = NT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
         hist[ch][0] = d;
      end
   endfunction

   // y = sat( floor((sum c[k]*x[k] + 2^(OS-1)) / 2^OS) )
   function automatic int ref_result(input int ch);
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < NT; k++) acc += longint'(coef_m[k]) * longint'(hist[ch][k]);
      r = (acc + (longint'(1) <<< (OS - 1))) >>> OS;
      if (r > (longint'(1) <<< (DW - 1)) - 1) r = (longint'(1) <<< (DW - 1)) - 1;
      if (r < -(longint'(1) <<< (DW - 1)))    r = -(longint'(1) <<< (DW - 1));
      return int'(r);
   endfunction

   task automatic write_coef(input int k, input int v);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 2'(k);
      coef_data = 16'(v);
      @(negedge clk);
      coef_we   = 1'b0;
      coef_m[k] = v;
   endtask

   // Send one sample, wait for its result, optionally stall the output and
   // optionally attempt a coefficient write while the MAC is running.
   task automatic send(input int ch, input int d, input bit use_ref, input int exp_c,
                       input int stall, input bit lock_wr, input string tag);
      logic signed [31:0] expv;
      logic signed [DW-1:0] held;
      int  waited;
      bit  seen;
      waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      out_ready = (stall == 0);
      in_valid  = 1'b1;
      in_ch     = 1'(ch);
      in_data   = 16'(d);
      @(negedge clk);
      in_valid  = 1'b0;
      model_push(ch, d);
      expv = use_ref ? ref_result(ch) : exp_c;
      check({tag, "_busy"}, in_ready, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         coef_we   = lock_wr && (i == 1);
         coef_addr = 2'd0;
         coef_data = 16'sh7FFF;
         @(negedge clk);
      end
      coef_we = 1'b0;
      check({tag, "_valid"}, seen, 1);
      check({tag, "_data"}, out_data, expv);
      check({tag, "_ch"}, out_ch, ch);
      held = out_data;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, "_stall_valid"}, out_valid, 1);
         check({tag, "_stall_data"}, out_data, held);
         check({tag, "_stall_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bit seen_v;
      int ch;
      int d;
      rst       = 1'b1;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      in_valid  = 1'b0;
      in_ch     = '0;
      in_data   = '0;
      out_ready = 1'b1;
      model_clear();

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ch", out_ch, 0);
      rst = 1'b0;
      #1;
      check("rel_in_ready", in_ready, 1);

      // Impulse response on ch0
      write_coef(0, 16'h4000);
      write_coef(1, 16'h2000);
      write_coef(2, 16'h1000);
      write_coef(3, 16'h0800);
      send(0, 16384, 0, 8192, 0, 0, "imp0");
      send(0, 0,     0, 4096, 0, 0, "imp1");
      send(0, 0,     0, 2048, 0, 0, "imp2");
      send(0, 0,     0, 1024, 0, 0, "imp3");
      send(0, 0,     0, 0,    0, 0, "imp4");

      // Channel isolation: ch0 impulse interleaved with ch1 zeros
      send(0, 16384, 0, 8192, 0, 0, "iso_c0_0");
      send(1, 0,     0, 0,    0, 0, "iso_c1_0");
      send(0, 0,     0, 4096, 0, 0, "iso_c0_1");
      send(1, 0,     0, 0,    0, 0, "iso_c1_1");
      send(0, 0,     0, 2048, 0, 0, "iso_c0_2");
      send(1, 0,     0, 0,    0, 0, "iso_c1_2");
      send(0, 0,     0, 1024, 0, 0, "iso_c0_3");
      send(1, 0,     0, 0,    0, 0, "iso_c1_3");

      // Rounding with c[0]=1
      write_coef(0, 1);
      write_coef(1, 0);
      write_coef(2, 0);
      write_coef(3, 0);
      send(0, 16384,  0, 1,  0, 0, "rnd_p16384");
      send(0, 16383,  0, 0,  0, 0, "rnd_p16383");
      send(0, -16384, 0, 0,  0, 0, "rnd_m16384");
      send(0, -16385, 0, -1, 0, 0, "rnd_m16385");

      // Saturation with all coefficients 0x7FFF
      for (int k = 0; k < NT; k++) write_coef(k, 16'h7FFF);
      send(0, 32767,  1, 0,      0, 0, "sat_p1");
      send(0, 32767,  1, 0,      0, 0, "sat_p2");
      send(0, 32767,  1, 0,      0, 0, "sat_p3");
      send(0, 32767,  0, 32767,  0, 0, "sat_p4");
      send(0, -32768, 1, 0,      0, 0, "sat_n1");
      send(0, -32768, 1, 0,      0, 0, "sat_n2");
      send(0, -32768, 1, 0,      0, 0, "sat_n3");
      send(0, -32768, 0, -32768, 0, 0, "sat_n4");

      // Backpressure and coefficient lock during MAC
      write_coef(0, 16'h4000);
      write_coef(1, 16'h2000);
      write_coef(2, 16'h1000);
      write_coef(3, 16'h0800);
      send(1, 1000, 0, 500,  5, 1, "bp_stall");
      send(1, 2000, 0, 1250, 0, 0, "bp_after_lock");

      // Reset in the middle of a MAC sequence
      while (in_ready !== 1'b1) @(negedge clk);
      in_valid = 1'b1;
      in_ch    = 1'b0;
      in_data  = 16'sd5000;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      check("mid_rel_in_ready", in_ready, 1);
      seen_v = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen_v = 1'b1;
      end
      check("mid_no_stale_out", seen_v, 0);
      send(0, 16384, 0, 0, 0, 0, "mid_imp_cleared");

      // Randomized traffic against the reference model
      for (int k = 0; k < NT; k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768);
      for (int n = 0; n < 40; n++) begin
         if (n % 10 == 9) write_coef(int'($urandom_range(0, NT - 1)),
                                     int'($urandom_range(0, 65535)) - 32768);
         ch = int'($urandom_range(0, NC - 1));
         d  = int'($urandom_range(0, 65535)) - 32768;
         send(ch, d, 1, 0, int'($urandom_range(0, 2)), 0, $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
